// File: rtl/vga_scan_gen.sv
// 640x480@60 raster-scan timing generator: scan counters, phase FSMs and registered sync/enable decodes.
// Optional build macro VGA_PIXEL_EN_EN adds a pixel_en port that gates every register update.
module vga_scan_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       in_clk,
   input  logic       reset,
`ifdef VGA_PIXEL_EN_EN
   input  logic       pixel_en,
`endif
   output logic [9:0] x_out,
   output logic [9:0] y_out,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_end,
   output logic       frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FP - 1);
   localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FP - 1);
   localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
         $error("vga_scan_gen: H_TOTAL and V_TOTAL must not exceed 1024");
      end
   endgenerate

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

   h_state_t   r_h_state, w_h_next;
   v_state_t   r_v_state, w_v_next;
   logic [9:0] r_x, r_y, w_x_next, w_y_next;
   logic       r_hsync, r_vsync, r_display_on, r_line_end, r_frame_end;
   logic       w_hsync_next, w_vsync_next, w_display_next, w_line_end_next, w_frame_end_next;
   logic       w_adv, w_line_wrap;

`ifdef VGA_PIXEL_EN_EN
   assign w_adv = pixel_en;
`else
   assign w_adv = 1'b1;
`endif

   assign w_line_wrap = (r_x == H_LAST);

   always_comb begin
      w_x_next  = r_x;
      w_y_next  = r_y;
      w_h_next  = r_h_state;
      w_v_next  = r_v_state;
      if (w_adv) begin
         w_x_next = w_line_wrap ? 10'd0 : r_x + 10'd1;
         unique case (r_h_state)
            H_ACT:   if (r_x == H_A_END) w_h_next = H_FRONT;
            H_FRONT: if (r_x == H_F_END) w_h_next = H_SYNCP;
            H_SYNCP: if (r_x == H_S_END) w_h_next = H_BACK;
            H_BACK:  if (w_line_wrap)    w_h_next = H_ACT;
            default: w_h_next = H_ACT;
         endcase
         if (w_line_wrap) begin
            w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            unique case (r_v_state)
               V_ACT:   if (r_y == V_A_END) w_v_next = V_FRONT;
               V_FRONT: if (r_y == V_F_END) w_v_next = V_SYNCP;
               V_SYNCP: if (r_y == V_S_END) w_v_next = V_BACK;
               V_BACK:  if (r_y == V_LAST)  w_v_next = V_ACT;
               default: w_v_next = V_ACT;
            endcase
         end
      end
   end

   // Decodes are taken from the next state/position so the registered outputs line up with the counters.
   always_comb begin
      w_hsync_next     = (w_h_next != H_SYNCP);
      w_vsync_next     = (w_v_next != V_SYNCP);
      w_display_next   = (w_h_next == H_ACT) && (w_v_next == V_ACT);
      w_line_end_next  = (w_x_next == H_LAST);
      w_frame_end_next = (w_x_next == H_LAST) && (w_y_next == V_LAST);
   end

   always_ff @(posedge in_clk) begin
      if (!reset) begin
         r_x          <= 10'd0;
         r_y          <= 10'd0;
         r_h_state    <= H_ACT;
         r_v_state    <= V_ACT;
         r_hsync      <= 1'b1;
         r_vsync      <= 1'b1;
         r_display_on <= 1'b1;
         r_line_end   <= 1'b0;
         r_frame_end  <= 1'b0;
      end else begin
         r_x          <= w_x_next;
         r_y          <= w_y_next;
         r_h_state    <= w_h_next;
         r_v_state    <= w_v_next;
         r_hsync      <= w_hsync_next;
         r_vsync      <= w_vsync_next;
         r_display_on <= w_display_next;
         r_line_end   <= w_line_end_next;
         r_frame_end  <= w_frame_end_next;
      end
   end

   assign x_out      = r_x;
   assign y_out      = r_y;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign display_on = r_display_on;
   assign line_end   = r_line_end;
   assign frame_end  = r_frame_end;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a reduced-size instance plus a default 640x480 instance, both checked every
// cycle against an advance-count model; honours VGA_PIXEL_EN_EN when defined.
module tb_vga_scan_gen;

   localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 3;
   localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;
   localparam int FHT = 800, FVT = 525;

   logic clk = 1'b0;
   logic reset = 1'b0;
`ifdef VGA_PIXEL_EN_EN
   logic pixel_en = 1'b1;
`endif

   logic [9:0] s_x, s_y, f_x, f_y;
   logic s_hs, s_vs, s_de, s_le, s_fe;
   logic f_hs, f_vs, f_de, f_le, f_fe;

   always #5 clk = ~clk;

   vga_scan_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) dut (
      .in_clk(clk), .reset(reset),
`ifdef VGA_PIXEL_EN_EN
      .pixel_en(pixel_en),
`endif
      .x_out(s_x), .y_out(s_y), .hsync(s_hs), .vsync(s_vs),
      .display_on(s_de), .line_end(s_le), .frame_end(s_fe)
   );

   vga_scan_gen dut_full (
      .in_clk(clk), .reset(reset),
`ifdef VGA_PIXEL_EN_EN
      .pixel_en(pixel_en),
`endif
      .x_out(f_x), .y_out(f_y), .hsync(f_hs), .vsync(f_vs),
      .display_on(f_de), .line_end(f_le), .frame_end(f_fe)
   );

   typedef struct {
      int x; int y;
      bit hs; bit vs; bit de; bit le; bit fe;
   } exp_t;

   typedef struct {
      bit rst; int cyc;
      int x; int y;
      bit hs; bit vs; bit de; bit le; bit fe;
   } vec_t;

   int vecs = 0;
   int miscmp = 0;
   int ns = 0;   // advances since last reset, small instance
   int nf = 0;   // advances since last reset, full instance

   // Position and decodes follow directly from the number of advances since reset.
   function automatic exp_t model(int n, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb);
      exp_t e;
      int ht, vt;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      e.x  = n % ht;
      e.y  = (n / ht) % vt;
      e.hs = !(e.x >= ha + hf && e.x < ha + hf + hs);
      e.vs = !(e.y >= va + vf && e.y < va + vf + vs);
      e.de = (e.x < ha) && (e.y < va);
      e.le = (e.x == ht - 1);
      e.fe = (e.x == ht - 1) && (e.y == vt - 1);
      return e;
   endfunction

   task automatic cmp(string name, int act, int exp);
      vecs++;
      if (act != exp) begin
         miscmp++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      exp_t e;
      e = model(ns, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      cmp("small.x", int'(s_x), e.x);
      cmp("small.y", int'(s_y), e.y);
      cmp("small.hsync", int'(s_hs), int'(e.hs));
      cmp("small.vsync", int'(s_vs), int'(e.vs));
      cmp("small.display_on", int'(s_de), int'(e.de));
      cmp("small.line_end", int'(s_le), int'(e.le));
      cmp("small.frame_end", int'(s_fe), int'(e.fe));
      e = model(nf, 640, 16, 96, 48, 480, 10, 2, 33);
      cmp("full.x", int'(f_x), e.x);
      cmp("full.y", int'(f_y), e.y);
      cmp("full.hsync", int'(f_hs), int'(e.hs));
      cmp("full.vsync", int'(f_vs), int'(e.vs));
      cmp("full.display_on", int'(f_de), int'(e.de));
      cmp("full.line_end", int'(f_le), int'(e.le));
      cmp("full.frame_end", int'(f_fe), int'(e.fe));
   endtask

   // One clock: update the model at the edge, then compare on the falling edge.
   task automatic tick();
      bit adv;
`ifdef VGA_PIXEL_EN_EN
      adv = pixel_en;
`else
      adv = 1'b1;
`endif
      @(posedge clk);
      if (!reset) begin
         ns = 0;
         nf = 0;
      end else if (adv) begin
         ns = (ns + 1) % (SHT * SVT);
         nf = (nf + 1) % (FHT * FVT);
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t tbl[16];
   int   lv_count;

   initial begin
      tbl[0]  = '{0,   5,  0,  0, 1, 1, 1, 0, 0};
      tbl[1]  = '{1,   1,  1,  0, 1, 1, 1, 0, 0};
      tbl[2]  = '{1,  19, 20,  0, 1, 1, 0, 0, 0};
      tbl[3]  = '{1,   3, 23,  0, 0, 1, 0, 0, 0};
      tbl[4]  = '{1,   3, 26,  0, 0, 1, 0, 0, 0};
      tbl[5]  = '{1,   1, 27,  0, 1, 1, 0, 0, 0};
      tbl[6]  = '{1,   2, 29,  0, 1, 1, 0, 1, 0};
      tbl[7]  = '{1,   1,  0,  1, 1, 1, 1, 0, 0};
      tbl[8]  = '{1, 389, 29, 13, 1, 1, 0, 1, 0};
      tbl[9]  = '{1,   1,  0, 14, 1, 0, 0, 0, 0};
      tbl[10] = '{1,  60,  0, 16, 1, 1, 0, 0, 0};
      tbl[11] = '{1,  89, 29, 18, 1, 1, 0, 1, 1};
      tbl[12] = '{1,   1,  0,  0, 1, 1, 1, 0, 0};
      tbl[13] = '{1, 160, 10,  5, 1, 1, 1, 0, 0};
      tbl[14] = '{0,   1,  0,  0, 1, 1, 1, 0, 0};
      tbl[15] = '{1,   1,  1,  0, 1, 1, 1, 0, 0};

      for (int v = 0; v < 16; v++) begin
         reset = tbl[v].rst;
         ticks(tbl[v].cyc);
         cmp("tbl.x", int'(s_x), tbl[v].x);
         cmp("tbl.y", int'(s_y), tbl[v].y);
         cmp("tbl.hsync", int'(s_hs), int'(tbl[v].hs));
         cmp("tbl.vsync", int'(s_vs), int'(tbl[v].vs));
         cmp("tbl.display_on", int'(s_de), int'(tbl[v].de));
         cmp("tbl.line_end", int'(s_le), int'(tbl[v].le));
         cmp("tbl.frame_end", int'(s_fe), int'(tbl[v].fe));
         $display("vec %0d: rst=%0b cycles=%0d -> x=%0d y=%0d hs=%0b vs=%0b de=%0b le=%0b fe=%0b",
                  v, tbl[v].rst, tbl[v].cyc, s_x, s_y, s_hs, s_vs, s_de, s_le, s_fe);
      end

      // Full-size line: sync window 656..751, blanking from 640, wrap after 799.
      reset = 1'b0; tick();
      reset = 1'b1;
      ticks(640);
      cmp("full.x@640", int'(f_x), 640);
      cmp("full.de@640", int'(f_de), 0);
      ticks(16);
      cmp("full.hs@656", int'(f_hs), 0);
      ticks(95);
      cmp("full.hs@751", int'(f_hs), 0);
      ticks(1);
      cmp("full.hs@752", int'(f_hs), 1);
      ticks(47);
      cmp("full.le@799", int'(f_le), 1);
      ticks(1);
      cmp("full.x@wrap", int'(f_x), 0);
      cmp("full.y@wrap", int'(f_y), 1);
      ticks(900);
      $display("full line: x=%0d y=%0d after 1700 advances", f_x, f_y);

      // Last visible address appears once per frame, one cycle each.
      reset = 1'b0; tick();
      reset = 1'b1;
      lv_count = 0;
      for (int i = 0; i < 3 * SHT * SVT; i++) begin
         tick();
         if (int'(s_x) == SHA - 1 && int'(s_y) == SVA - 1) lv_count++;
      end
      cmp("last_visible_count", lv_count, 3);
      $display("last visible: %0d hits in 3 frames", lv_count);

      // Randomised run with sparse resets (and random enable when present).
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 999) != 0);
`ifdef VGA_PIXEL_EN_EN
         pixel_en = $urandom_range(0, 1) != 0;
`endif
         tick();
      end
      $display("random run: 4000 cycles, ns=%0d nf=%0d", ns, nf);

`ifdef VGA_PIXEL_EN_EN
      // Alternate-cycle enable: one line takes twice its length in clocks; enable low freezes.
      pixel_en = 1'b1;
      reset = 1'b0; tick();
      reset = 1'b1;
      for (int i = 0; i < 2 * SHT; i++) begin
         pixel_en = (i % 2 == 0);
         tick();
      end
      cmp("pen.x_after_line", int'(s_x), 0);
      cmp("pen.y_after_line", int'(s_y), 1);
      pixel_en = 1'b0;
      ticks(10);
      cmp("pen.x_frozen", int'(s_x), 0);
      cmp("pen.y_frozen", int'(s_y), 1);
      pixel_en = 1'b1;
      ticks(3);
      cmp("pen.x_resume", int'(s_x), 3);
      $display("pixel_en sequence: x=%0d y=%0d", s_x, s_y);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
